ysyx_22040895_ifu: RTL

- Instruction-fetch stage directly downstream of the PC register.
- Latches each PC presented with chip-enable and issues a read on the instruction-memory request/grant/response bus.
- Selects the 32-bit instruction word from the 64-bit response beat and hands {inst, pc} to decode over a valid/ready handshake.
- Drives a busy signal back so the PC stage holds while a fetch is outstanding; supports flush on branch redirect.

---
 rtl/ysyx_22040895_ifu_pkg.sv | 24 ++
 rtl/ysyx_22040895_ifu_wsel.sv | 12 +
 rtl/ysyx_22040895_ifu.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ysyx_22040895_ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ysyx_22040895_ifu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DATA_W = 64;

    localparam logic [INST_W-1:0] NOP_INST    = 32'h0000_0013;
    localparam logic              RST_ENABLE  = 1'b0;
    localparam logic              CHIP_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_REQ   = 3'd1,
        IFU_WAIT  = 3'd2,
        IFU_VALID = 3'd3,
        IFU_DRAIN = 3'd4
    } ifu_state_e;

    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22040895_ifu_wsel.sv
// Picks the 32-bit word addressed by addr[2] out of a 64-bit memory beat.
module ysyx_22040895_ifu_wsel
    import ysyx_22040895_ifu_pkg::*;
(
    input  logic              sel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [INST_W-1:0] word_o
);

    assign word_o = sel_i ? data_i[DATA_W-1:INST_W] : data_i[INST_W-1:0];

endmodule

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch: latches the PC, performs one imem read, hands {inst, pc}
// to decode over valid/ready, and stalls the PC stage while a fetch is in flight.
module ysyx_22040895_ifu
    import ysyx_22040895_ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              ce_i,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [XLEN-1:0]   imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              misalign_o,
    output logic              fetch_busy_o
);

    ifu_state_e        state_q;
    logic [XLEN-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;
    logic              misalign_q;
    logic              req_q;
    logic              valid_q;
    logic              stale_q;
    logic [INST_W-1:0] rword;

    ysyx_22040895_ifu_wsel u_wsel (
        .sel_i  (pc_q[2]),
        .data_i (imem_rdata_i),
        .word_o (rword)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= IFU_IDLE;
            pc_q       <= '0;
            inst_q     <= '0;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            // Remember a granted request that reset orphaned; its beat may still arrive.
            stale_q    <= (state_q == IFU_WAIT) || (state_q == IFU_DRAIN) ||
                          ((state_q == IFU_REQ) && imem_gnt_i) ||
                          (stale_q && !imem_rvalid_i);
        end else begin
            if (imem_rvalid_i) begin
                stale_q <= 1'b0;
            end
            case (state_q)
                IFU_IDLE: begin
                    if ((ce_i == CHIP_ENABLE) && !flush_i) begin
                        pc_q <= pc_i;
                        if (is_misaligned(pc_i)) begin
                            inst_q     <= NOP_INST;
                            misalign_q <= 1'b1;
                            valid_q    <= 1'b1;
                            state_q    <= IFU_VALID;
                        end else begin
                            misalign_q <= 1'b0;
                            req_q      <= 1'b1;
                            state_q    <= IFU_REQ;
                        end
                    end
                end
                IFU_REQ: begin
                    if (imem_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= flush_i ? IFU_DRAIN : IFU_WAIT;
                    end else if (flush_i) begin
                        req_q   <= 1'b0;
                        state_q <= IFU_IDLE;
                    end
                end
                IFU_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (flush_i) begin
                            state_q <= IFU_IDLE;
                        end else begin
                            inst_q  <= rword;
                            valid_q <= 1'b1;
                            state_q <= IFU_VALID;
                        end
                    end else if (flush_i) begin
                        state_q <= IFU_DRAIN;
                    end
                end
                IFU_VALID: begin
                    if (flush_i || inst_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IFU_IDLE;
                    end
                end
                IFU_DRAIN: begin
                    if (imem_rvalid_i) begin
                        state_q <= IFU_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IFU_IDLE;
                end
            endcase
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = {pc_q[XLEN-1:3], 3'b000};
    assign inst_o       = inst_q;
    assign inst_pc_o    = pc_q;
    assign inst_valid_o = valid_q;
    assign misalign_o   = misalign_q;
    assign fetch_busy_o = (state_q != IFU_IDLE) &&
                          !((state_q == IFU_VALID) && inst_ready_i);

    // A response beat is only legal while one is outstanding.
    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
        imem_rvalid_i |-> ((state_q == IFU_WAIT) || (state_q == IFU_DRAIN) || stale_q));

endmodule
